rr_arbiter16: RTL and testbench
===============================

// Module: rr_arbiter16
// PURPOSE
//  Round-robin arbiter sharing one resource among 16 requesters. Grant is one-hot,
//  MSB-first ([0:15], bit 0 = requester 0), the same encoding as the 4-to-16 decoder
//  outputs. A registered 4-bit index of the winner is also produced. Sits in front of
//  any shared datapath (bus, memory port, display driver) steered by the dec4to16 tree.
// PARAMETERS
//  HOLDW     4    width of hold-time counter
//  MAX_HOLD  12   max cycles one grant may be held; 0 disables timeout
// PORTS
//  Clock     in   1      rising-edge clock, the only clock
//  Resetn    in   1      synchronous reset, active-low
//  En        in   1      arbitration enable; 0 blocks new grants only
//  Req       in   [0:15] request per requester, level, held until served
//  Done      in   1      current holder releases resource (1-cycle pulse)
//  Grant     out  [0:15] one-hot grant, all-zero when no holder
//  GrantIdx  out  [3:0]  index of current/last winner
//  Valid     out  1      1 while Grant is non-zero
//  Tmo       out  1      1-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  - Reset (Resetn=0 at posedge): Grant=0, GrantIdx=0, Valid=0, Tmo=0, Ptr=0,
//    hold count=0, state=IDLE. Overrides everything, including mid-grant.
//  - All outputs registered. Internal Ptr[3:0] = first index of next search.
//  - States: IDLE, BUSY, GAP.
//  - IDLE: if En=1 and |Req: winner = first i with Req[i]=1 scanning
//    Ptr, Ptr+1, ... 15, 0, ... Ptr-1 (mod 16). Next cycle: Grant=one-hot(winner),
//    GrantIdx=winner, Valid=1, count=0, ->BUSY. Latency Req->Grant = 1 cycle.
//    En=0 or no Req: stay IDLE, outputs unchanged (Grant=0).
//  - BUSY: count increments each cycle (saturating at 2^HOLDW-1). Release when any of:
//    Done=1; Req[GrantIdx]=0; MAX_HOLD!=0 and count==MAX_HOLD-1.
//    On release: Grant=0, Valid=0, Ptr=GrantIdx+1 (wraps 15->0), ->GAP.
//    Tmo=1 for that one cycle only if release is due solely to timeout.
//    En=0 in BUSY does not revoke the current grant.
//  - GAP: one dead cycle (Grant=0) guaranteeing break-before-make; Tmo=0; ->IDLE.
//    Minimum spacing between two grants: grant drops at cycle t, next grant
//    earliest at t+2.
//  - Simultaneous Done and timeout: treated as Done, Tmo=0.
//  - Done while IDLE/GAP: ignored. Req changes outside IDLE sampling: ignored.
//  - Fairness: a continuously requesting input is granted within 16 grants.
//  - GrantIdx keeps last winner while Valid=0.
//  - Grant never has more than one bit set; Grant==0 iff Valid==0.
// TESTING
//  1 Reset: Resetn=0 mid-BUSY with Grant[5]=1 -> next edge Grant=0, Valid=0, Ptr=0.
//  2 Single req: Req[9]=1, En=1 from IDLE -> 1 cycle later Grant=bit9, GrantIdx=9;
//    Done pulse -> Grant=0 next edge, regrant of 9 two edges after that.
//  3 Rotation: Req all 1s, Done every 3rd cycle -> grant order 0,1,2,...,15,0.
//  4 Wrap: Ptr=14, Req[3] and Req[13]=1 -> grant 3 (13 skipped), Ptr becomes 4.
//  5 Timeout: MAX_HOLD=12, Req[7] held, no Done -> Grant held 12 cycles, then
//    Grant=0 with Tmo=1 for one cycle; Done+timeout same cycle -> Tmo=0.
//  6 Enable: En=0 with Req[2]=1 -> Grant stays 0; En dropped in BUSY -> grant kept
//    until Done; after release no new grant until En=1.

Source files
------------

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with registered one-hot grant, winner index,
// hold-time timeout and a one-cycle break-before-make gap between grants.
module rr_arbiter16 #(
    parameter int unsigned HOLDW    = 4,
    parameter int unsigned MAX_HOLD = 12
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        En,
    input  logic [0:15] Req,
    input  logic        Done,
    output logic [0:15] Grant,
    output logic [3:0]  GrantIdx,
    output logic        Valid,
    output logic        Tmo
);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    localparam int unsigned      TmoCount  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLDW-1:0] TmoCountW = TmoCount[HOLDW-1:0];
    localparam logic [HOLDW-1:0] CountMax  = '1;

    state_e           state_q, state_d;
    logic [0:15]      grant_q, grant_d;
    logic [3:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [HOLDW-1:0] count_q, count_d;

    logic       found;
    logic [3:0] winner;
    logic       user_rel;
    logic       tmo_hit;

    // First requester at or after ptr_q, wrapping modulo 16.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 0; i < 16; i++) begin
            if (!found && Req[ptr_q + 4'(i)]) begin
                found  = 1'b1;
                winner = ptr_q + 4'(i);
            end
        end
    end

    assign user_rel = Done || !Req[idx_q];
    assign tmo_hit  = (MAX_HOLD != 0) && (count_q == TmoCountW);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tmo_d   = 1'b0;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (En && found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    idx_d           = winner;
                    valid_d         = 1'b1;
                    count_d         = '0;
                    state_d         = StBusy;
                end
            end
            StBusy: begin
                count_d = (count_q == CountMax) ? count_q : count_q + 1'b1;
                if (user_rel || tmo_hit) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 4'd1;
                    // Tmo only when the timeout is the sole reason for release.
                    tmo_d   = tmo_hit && !user_rel;
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign Grant    = grant_q;
    assign GrantIdx = idx_q;
    assign Valid    = valid_q;
    assign Tmo      = tmo_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: directed vector table, hand-written corner sequences and
// random stimulus checked against a behavioural round-robin model.
module tb_rr_arbiter16;

    localparam int MaxHold = 12;

    logic        Clock;
    logic        Resetn;
    logic        En;
    logic [0:15] Req;
    logic        Done;
    logic [0:15] Grant;
    logic [3:0]  GrantIdx;
    logic        Valid;
    logic        Tmo;

    int total = 0;
    int bad   = 0;

    // Model: who holds the resource (-1 = nobody), how many cycles it has held it,
    // whether we are in the dead cycle after a release, and where the search starts.
    int m_holder = -1;
    int m_age    = 0;
    int m_last   = 0;
    int m_ptr    = 0;
    bit m_gap    = 0;
    bit m_tmo    = 0;

    rr_arbiter16 #(.HOLDW(4), .MAX_HOLD(MaxHold)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .En       (En),
        .Req      (Req),
        .Done     (Done),
        .Grant    (Grant),
        .GrantIdx (GrantIdx),
        .Valid    (Valid),
        .Tmo      (Tmo)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [0:15] onehot(input int i);
        logic [0:15] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rn, input logic en, input logic [0:15] req,
                                input logic done);
        bit timeout;
        if (!rn) begin
            m_holder = -1; m_age = 0; m_last = 0; m_ptr = 0; m_gap = 0; m_tmo = 0;
        end else if (m_holder >= 0) begin
            timeout = (MaxHold != 0) && (m_age + 1 == MaxHold);
            m_age++;
            m_tmo = 0;
            if (done || !req[m_holder] || timeout) begin
                m_tmo    = timeout && !done && req[m_holder];
                m_ptr    = (m_holder + 1) % 16;
                m_holder = -1;
                m_gap    = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
            m_tmo = 0;
        end else begin
            m_tmo = 0;
            if (en) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_holder < 0 && req[(m_ptr + k) % 16]) begin
                        m_holder = (m_ptr + k) % 16;
                        m_last   = m_holder;
                        m_age    = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rn, input logic en, input logic [0:15] req,
                        input logic done);
        logic [0:15] eg;
        Resetn = rn; En = en; Req = req; Done = done;
        @(posedge Clock);
        model_update(rn, en, req, done);
        #1;
        eg = (m_holder >= 0) ? onehot(m_holder) : '0;
        check("model_grant", 32'(Grant), 32'(eg));
        check("model_idx", 32'(GrantIdx), 32'(m_last));
        check("model_valid", 32'(Valid), 32'(m_holder >= 0));
        check("model_tmo", 32'(Tmo), 32'(m_tmo));
    endtask

    typedef struct {
        logic        en;
        logic [0:15] req;
        logic        done;
        logic        exp_valid;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic en, input logic [0:15] req, input logic done,
                                input logic ev, input logic [3:0] ei);
        vec_t v;
        v.en = en; v.req = req; v.done = done; v.exp_valid = ev; v.exp_idx = ei;
        return v;
    endfunction

    initial begin
        logic [0:15] r;
        logic [0:15] b313;
        logic [0:15] eg;
        int          order[$];
        logic        prev_valid;
        int          steps;

        b313 = onehot(3) | onehot(13);
        // Single request, regrant after Done, Req drop release.
        vecs[0]  = mk(1, onehot(9),  0, 1, 9);
        vecs[1]  = mk(1, onehot(9),  1, 0, 9);
        vecs[2]  = mk(1, onehot(9),  0, 0, 9);
        vecs[3]  = mk(1, onehot(9),  0, 1, 9);
        vecs[4]  = mk(1, '0,         0, 0, 9);
        vecs[5]  = mk(1, '0,         0, 0, 9);
        // Wrap: park pointer at 14, then 3 wins over 13.
        vecs[6]  = mk(1, onehot(13), 0, 1, 13);
        vecs[7]  = mk(1, onehot(13), 1, 0, 13);
        vecs[8]  = mk(1, b313,       0, 0, 13);
        vecs[9]  = mk(1, b313,       0, 1, 3);
        vecs[10] = mk(1, b313,       1, 0, 3);
        vecs[11] = mk(1, '1,         0, 0, 3);
        vecs[12] = mk(1, '1,         0, 1, 4);
        vecs[13] = mk(1, '1,         1, 0, 4);
        // Enable gating.
        vecs[14] = mk(0, onehot(2),  0, 0, 4);
        vecs[15] = mk(0, onehot(2),  0, 0, 4);
        vecs[16] = mk(0, onehot(2),  0, 0, 4);
        vecs[17] = mk(1, onehot(2),  0, 1, 2);
        vecs[18] = mk(0, onehot(2),  0, 1, 2);
        vecs[19] = mk(0, onehot(2),  0, 1, 2);
        vecs[20] = mk(0, onehot(2),  1, 0, 2);
        vecs[21] = mk(0, onehot(2),  0, 0, 2);
        vecs[22] = mk(0, onehot(2),  0, 0, 2);
        vecs[23] = mk(1, onehot(2),  0, 1, 2);
        vecs[24] = mk(1, onehot(2),  1, 0, 2);

        Resetn = 1'b0; En = 1'b0; Req = '0; Done = 1'b0;
        step(0, 0, '0, 0);
        step(0, 1, '1, 1);
        check("reset_grant", 32'(Grant), 32'h0);
        check("reset_idx", 32'(GrantIdx), 32'h0);
        check("reset_valid", 32'(Valid), 32'h0);
        check("reset_tmo", 32'(Tmo), 32'h0);

        for (int i = 0; i < 25; i++) begin
            step(1, vecs[i].en, vecs[i].req, vecs[i].done);
            eg = vecs[i].exp_valid ? onehot(int'(vecs[i].exp_idx)) : '0;
            check($sformatf("vec%0d_valid", i), 32'(Valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_idx", i), 32'(GrantIdx), 32'(vecs[i].exp_idx));
            check($sformatf("vec%0d_grant", i), 32'(Grant), 32'(eg));
        end

        // Reset in the middle of a grant to requester 5.
        step(1, 1, onehot(5), 0);
        step(1, 1, onehot(5), 0);
        check("pre_reset_grant5", 32'(Grant), 32'(onehot(5)));
        step(0, 1, onehot(5), 0);
        check("midbusy_reset_grant", 32'(Grant), 32'h0);
        check("midbusy_reset_valid", 32'(Valid), 32'h0);
        check("midbusy_reset_idx", 32'(GrantIdx), 32'h0);
        step(1, 1, '1, 0);
        check("post_reset_ptr0", 32'(GrantIdx), 32'h0);

        // Timeout, then Done coinciding with timeout.
        step(1, 1, '1, 1);
        step(1, 1, onehot(7), 0);
        step(1, 1, onehot(7), 0);
        check("tmo_grant7", 32'(Grant), 32'(onehot(7)));
        for (int k = 1; k < MaxHold; k++) begin
            step(1, 1, onehot(7), 0);
            check($sformatf("tmo_hold%0d", k), 32'(Valid), 32'h1);
            check($sformatf("tmo_quiet%0d", k), 32'(Tmo), 32'h0);
        end
        step(1, 1, onehot(7), 0);
        check("tmo_revoke_valid", 32'(Valid), 32'h0);
        check("tmo_pulse", 32'(Tmo), 32'h1);
        step(1, 1, onehot(7), 0);
        check("tmo_pulse_end", 32'(Tmo), 32'h0);
        step(1, 1, onehot(7), 0);
        check("tmo_regrant7", 32'(Valid), 32'h1);
        for (int k = 1; k < MaxHold; k++) step(1, 1, onehot(7), 0);
        step(1, 1, onehot(7), 1);
        check("done_tmo_valid", 32'(Valid), 32'h0);
        check("done_tmo_no_pulse", 32'(Tmo), 32'h0);

        // Rotation with all requesting and Done every third cycle.
        step(0, 0, '0, 0);
        prev_valid = 1'b0;
        steps = 0;
        while (order.size() < 17 && steps < 300) begin
            step(1, 1, '1, (steps % 3) == 2);
            if (Valid && !prev_valid) order.push_back(int'(GrantIdx));
            prev_valid = Valid;
            steps++;
        end
        check("rotation_count", 32'(order.size()), 32'd17);
        for (int j = 0; j < order.size(); j++)
            check($sformatf("rotation%0d", j), 32'(order[j]), 32'(j % 16));

        // Random stimulus with sticky requests so holds and timeouts occur.
        r = '0;
        for (int n = 0; n < 4000; n++) begin
            r = r ^ 16'($urandom & $urandom & $urandom);
            step($urandom_range(0, 299) != 0, $urandom_range(0, 7) != 0, r,
                 $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
